// File: rtl/frame_pipe_pkg.sv
// Shared types and constants for the VGA frame pipeline.
//   rgb_t          : RGB444 pixel
//   VGA_*          : 640x480@60 timing defaults
//   VGA_KEY_COLOR  : default transparent layer colour
//   bar_color()    : colour-bar table (white, yellow, cyan, green, magenta, red, blue, black)
package frame_pipe_pkg;

    typedef logic [11:0] rgb_t;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam rgb_t VGA_KEY_COLOR = 12'hF0F;

    function automatic rgb_t bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return 12'hFFF;
            3'd1:    return 12'hFF0;
            3'd2:    return 12'h0FF;
            3'd3:    return 12'h0F0;
            3'd4:    return 12'hF0F;
            3'd5:    return 12'hF00;
            3'd6:    return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

endpackage

// File: rtl/vga_frame_pipe_if.sv
// Bus between the scan pipeline and its neighbours (game logic, frame BRAM, VGA pins).
//   master : the pipeline (drives counters, mem_addr, colour and syncs)
//   slave  : the environment (drives layer_px and mem_rdata)
interface vga_frame_pipe_if #(
    parameter int ADDR_W     = 17,
    parameter int COLOR_W    = 12,
    parameter int NUM_LAYERS = 2
);
    logic [10:0]                         h_cnt;
    logic [10:0]                         v_cnt;
    logic                                frame_start;
    logic [NUM_LAYERS-1:0][COLOR_W-1:0]  layer_px;
    logic [ADDR_W-1:0]                   mem_addr;
    logic [COLOR_W-1:0]                  mem_rdata;
    logic [3:0]                          vga_r;
    logic [3:0]                          vga_g;
    logic [3:0]                          vga_b;
    logic                                hsync;
    logic                                vsync;
    logic                                valid;

    modport master (
        output h_cnt, v_cnt, frame_start, mem_addr,
        output vga_r, vga_g, vga_b, hsync, vsync, valid,
        input  layer_px, mem_rdata
    );

    modport slave (
        input  h_cnt, v_cnt, frame_start, mem_addr,
        input  vga_r, vga_g, vga_b, hsync, vsync, valid,
        output layer_px, mem_rdata
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA scan counters (stage 0).
//   clk, rst     : clock, synchronous active-high reset
//   pix_ce       : pixel-clock enable
//   h_cnt, v_cnt : current scan position
//   frame_start  : high while pix_ce is high at (0,0); a single clk since the tick moves h off 0
//   active       : position inside the visible area
//   hs_on, vs_on : position inside the sync pulse (polarity applied downstream)
module vga_timing_gen
    import frame_pipe_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
    output logic [10:0] h_cnt,
    output logic [10:0] v_cnt,
    output logic        frame_start,
    output logic        active,
    output logic        hs_on,
    output logic        vs_on
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_cnt == 11'(H_TOTAL - 1)) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == 11'(V_TOTAL - 1)) ? 11'd0 : v_cnt + 11'd1;
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end
        end
    end

    assign frame_start = pix_ce && !rst && (h_cnt == '0) && (v_cnt == '0);
    assign active      = (h_cnt < 11'(H_ACTIVE)) && (v_cnt < 11'(V_ACTIVE));
    assign hs_on       = (h_cnt >= 11'(H_ACTIVE + H_FP)) &&
                         (h_cnt <  11'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_on       = (v_cnt >= 11'(V_ACTIVE + V_FP)) &&
                         (v_cnt <  11'(V_ACTIVE + V_FP + V_SYNC));
endmodule

// File: rtl/vga_frame_pipe.sv
// VGA scan pipeline: counters (stage 0), framebuffer address + layer capture (stage 1),
// compositing and sync/valid alignment (stage 2). Two pix_ce ticks from counter to pins.
//   clk, rst   : clock, synchronous active-high reset (wins over pix_ce)
//   pix_ce     : pixel-clock enable; may be high every clk
//   test_mode  : colour-bar select, only honoured with FRAME_PIPE_TEST_PATTERN_EN defined
//   bus        : vga_frame_pipe_if.master (counters, frame_start, mem bus, layers, RGB, syncs)
// Optional: FRAME_PIPE_TEST_PATTERN_EN adds 8 vertical bars replacing the composite.
module vga_frame_pipe
    import frame_pipe_pkg::*;
#(
    parameter int                 H_ACTIVE   = VGA_H_ACTIVE,
    parameter int                 H_FP       = VGA_H_FP,
    parameter int                 H_SYNC     = VGA_H_SYNC,
    parameter int                 H_BP       = VGA_H_BP,
    parameter int                 V_ACTIVE   = VGA_V_ACTIVE,
    parameter int                 V_FP       = VGA_V_FP,
    parameter int                 V_SYNC     = VGA_V_SYNC,
    parameter int                 V_BP       = VGA_V_BP,
    parameter bit                 SYNC_POL   = 1'b0,
    parameter int                 SCALE_SH   = 1,
    parameter int                 ADDR_W     = 17,
    parameter int                 NUM_LAYERS = 2,
    parameter int                 COLOR_W    = 12,
    parameter logic [COLOR_W-1:0] KEY_COLOR  = VGA_KEY_COLOR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_ce,
    input  logic              test_mode,
    vga_frame_pipe_if.master  bus
);
    localparam int     FB_W     = H_ACTIVE >> SCALE_SH;
    localparam longint FB_WORDS = longint'(FB_W) * longint'(V_ACTIVE >> SCALE_SH);

    if (FB_WORDS > (longint'(1) << ADDR_W)) begin : g_addr_chk
        $error("vga_frame_pipe: framebuffer does not fit in ADDR_W");
    end
    if (COLOR_W != 12) begin : g_color_chk
        $error("vga_frame_pipe: only RGB444 (COLOR_W=12) is supported");
    end

    logic active, hs_on, vs_on;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk        (clk),
        .rst        (rst),
        .pix_ce     (pix_ce),
        .h_cnt      (bus.h_cnt),
        .v_cnt      (bus.v_cnt),
        .frame_start(bus.frame_start),
        .active     (active),
        .hs_on      (hs_on),
        .vs_on      (vs_on)
    );

    // Stage 1: address is formed in ADDR_W bits; the elab check guarantees no overflow.
    logic [ADDR_W-1:0]                  addr_d, addr1;
    logic [NUM_LAYERS-1:0][COLOR_W-1:0] lay1;
    logic                               act1, hs1, vs1;

    assign addr_d = ADDR_W'(bus.h_cnt >> SCALE_SH) +
                    ADDR_W'(FB_W) * ADDR_W'(bus.v_cnt >> SCALE_SH);

    // Stage 2 colour select: scanning from the lowest-priority layer up means the
    // last non-key hit is layer with the smallest index.
    logic [COLOR_W-1:0] comp, pix;

    always_comb begin
        comp = bus.mem_rdata;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (lay1[i] != KEY_COLOR) comp = lay1[i];
        end
    end

`ifdef FRAME_PIPE_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    logic [2:0] bar1;
    logic       tm1;

    // Bar index follows the pixel through stage 1 so the pattern keeps the same latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            bar1 <= '0;
            tm1  <= 1'b0;
        end else if (pix_ce) begin
            bar1 <= 3'(bus.h_cnt / 11'(BAR_W));
            tm1  <= test_mode;
        end
    end

    assign pix = tm1 ? bar_color(bar1) : comp;
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
    assign pix = comp;
`endif

    rgb_t rgb2;
    logic vld2, hs2, vs2;

    always_ff @(posedge clk) begin
        if (rst) begin
            act1  <= 1'b0;
            hs1   <= 1'b0;
            vs1   <= 1'b0;
            lay1  <= '0;
            addr1 <= '0;
            rgb2  <= '0;
            vld2  <= 1'b0;
            hs2   <= ~SYNC_POL;
            vs2   <= ~SYNC_POL;
        end else if (pix_ce) begin
            act1  <= active;
            hs1   <= hs_on;
            vs1   <= vs_on;
            lay1  <= bus.layer_px;
            addr1 <= active ? addr_d : '0;
            rgb2  <= act1 ? pix : '0;
            vld2  <= act1;
            hs2   <= hs1 ? SYNC_POL : ~SYNC_POL;
            vs2   <= vs1 ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign bus.mem_addr = addr1;
    assign bus.vga_r    = rgb2[11:8];
    assign bus.vga_g    = rgb2[7:4];
    assign bus.vga_b    = rgb2[3:0];
    assign bus.hsync    = hs2;
    assign bus.vsync    = vs2;
    assign bus.valid    = vld2;
endmodule

// File: tb/tb_vga_frame_pipe.sv
// Bench for vga_frame_pipe: 640-wide lines with a short 15-line frame so vertical wrap
// is reachable. A position/pixel model predicts every output each clk; directed steps
// with literal values pin the model at known points.
module tb_vga_frame_pipe;
    localparam int HT  = 800;
    localparam int VA  = 8;
    localparam int VFP = 2;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int VT  = VA + VFP + VS + VBP;
`ifdef FRAME_PIPE_TEST_PATTERN_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_ce = 1'b0;
    logic test_mode = 1'b0;
    logic chk_en = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    vga_frame_pipe_if #(.ADDR_W(17), .COLOR_W(12), .NUM_LAYERS(2)) bus ();

    vga_frame_pipe #(.V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)) dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .test_mode(test_mode), .bus(bus)
    );

    always #5 clk = ~clk;

    // Environment: layers are functions of h only, BRAM returns addr ^ 0x123.
    function automatic logic [11:0] env_l0(int h);
        return (h % 3 == 1) ? 12'hABC : 12'hF0F;
    endfunction
    function automatic logic [11:0] env_l1(int h);
        return (h % 2 == 1) ? 12'h0F0 : 12'hF0F;
    endfunction
    function automatic logic [11:0] env_mem(logic [16:0] a);
        return a[11:0] ^ 12'h123;
    endfunction

    assign bus.layer_px[0] = env_l0(int'(bus.h_cnt));
    assign bus.layer_px[1] = env_l1(int'(bus.h_cnt));
    assign bus.mem_rdata   = env_mem(bus.mem_addr);

    typedef struct packed {
        logic [11:0] rgb;
        logic        vld;
        logic        hs;
        logic        vs;
        logic [16:0] addr;
    } exp_t;

    localparam exp_t EXP_RST = '{rgb: 12'h0, vld: 1'b0, hs: 1'b1, vs: 1'b1, addr: 17'h0};

    function automatic logic [11:0] bar_exp(int idx);
        case (idx)
            0: return 12'hFFF;  1: return 12'hFF0;  2: return 12'h0FF;  3: return 12'h0F0;
            4: return 12'hF0F;  5: return 12'hF00;  6: return 12'h00F;  default: return 12'h000;
        endcase
    endfunction

    // What the pins must show for the pixel at (h,v).
    function automatic exp_t pix_exp(int h, int v, bit tm);
        exp_t e;
        bit   act;
        act    = (h < 640) && (v < VA);
        e.addr = act ? 17'((h / 2) + 320 * (v / 2)) : 17'd0;
        e.vld  = act;
        e.hs   = !(h >= 656 && h < 752);
        e.vs   = !(v >= VA + VFP && v < VA + VFP + VS);
        if (!act)                     e.rgb = 12'h000;
        else if (tm && PAT_EN)        e.rgb = bar_exp(h / 80);
        else if (env_l0(h) != 12'hF0F) e.rgb = env_l0(h);
        else if (env_l1(h) != 12'hF0F) e.rgb = env_l1(h);
        else                          e.rgb = env_mem(e.addr);
        return e;
    endfunction

    int   mh = 0;
    int   mv = 0;
    exp_t p1 = EXP_RST;
    exp_t p2 = EXP_RST;

    always @(posedge clk) begin
        if (rst) begin
            mh <= 0;
            mv <= 0;
            p1 <= EXP_RST;
            p2 <= EXP_RST;
        end else if (pix_ce) begin
            p2 <= p1;
            p1 <= pix_exp(mh, mv, test_mode);
            if (mh == HT - 1) begin
                mh <= 0;
                mv <= (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh <= mh + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("h_cnt", 32'(bus.h_cnt), 32'(mh));
            chk("v_cnt", 32'(bus.v_cnt), 32'(mv));
            chk("mem_addr", 32'(bus.mem_addr), 32'(p1.addr));
            chk("rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(p2.rgb));
            chk("valid", 32'(bus.valid), 32'(p2.vld));
            chk("hsync", 32'(bus.hsync), 32'(p2.hs));
            chk("vsync", 32'(bus.vsync), 32'(p2.vs));
            chk("frame_start", 32'(bus.frame_start),
                32'(pix_ce && !rst && mh == 0 && mv == 0));
        end
    end

    task automatic step(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            pix_ce = 1'b1;
            @(posedge clk); #1;
            pix_ce = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic run_to(input int h, input int v);
        int n;
        n = 0;
        while (!(int'(bus.h_cnt) == h && int'(bus.v_cnt) == v) && n < 20000) begin
            step(1, 0);
            n++;
        end
        chk("run_to_reached", 32'(int'(bus.h_cnt) == h && int'(bus.v_cnt) == v), 32'd1);
    endtask

    function automatic logic [31:0] rgb_now();
        return 32'({bus.vga_r, bus.vga_g, bus.vga_b});
    endfunction

    initial begin
        // Reset with pix_ce high: reset must win.
        rst = 1'b1; pix_ce = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("rst_h", 32'(bus.h_cnt), 32'd0);
        chk("rst_v", 32'(bus.v_cnt), 32'd0);
        chk("rst_hsync", 32'(bus.hsync), 32'd1);
        chk("rst_vsync", 32'(bus.vsync), 32'd1);
        chk("rst_rgb", rgb_now(), 32'h000);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_fs", 32'(bus.frame_start), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; pix_ce = 1'b1;
        @(negedge clk);
        chk("fs_first", 32'(bus.frame_start), 32'd1);
        @(posedge clk); #1;
        pix_ce = 1'b0;
        @(negedge clk);
        chk("fs_drop", 32'(bus.frame_start), 32'd0);
        chk("tick1_h", 32'(bus.h_cnt), 32'd1);
        repeat (2) begin @(posedge clk); #1; end

        // pix_ce every 4th clk: compositing, hsync window, line wrap.
        step(1, 3);   @(negedge clk); chk("px0_mem", rgb_now(), 32'h123);
                                      chk("px0_valid", 32'(bus.valid), 32'd1);
        step(4, 3);   @(negedge clk); chk("px4_layer0", rgb_now(), 32'hABC);
        step(1, 3);   @(negedge clk); chk("px5_layer1", rgb_now(), 32'h0F0);
        step(650, 3); @(negedge clk); chk("hs_655", 32'(bus.hsync), 32'd1);
        step(1, 3);   @(negedge clk); chk("hs_656", 32'(bus.hsync), 32'd0);
        step(95, 3);  @(negedge clk); chk("hs_751", 32'(bus.hsync), 32'd0);
        step(1, 3);   @(negedge clk); chk("hs_752", 32'(bus.hsync), 32'd1);
        step(45, 3);  @(negedge clk); chk("h_799", 32'(bus.h_cnt), 32'd799);
        step(1, 3);   @(negedge clk); chk("hwrap_h", 32'(bus.h_cnt), 32'd0);
                                      chk("hwrap_v", 32'(bus.v_cnt), 32'd1);

        // Full rate: address generation and blanking.
        run_to(10, 3);
        step(1, 0); @(negedge clk); chk("addr_10_3", 32'(bus.mem_addr), 32'd325);
        step(1, 0); @(negedge clk); chk("rgb_10_3", rgb_now(), 32'hABC);
        run_to(700, 3);
        step(1, 0); @(negedge clk); chk("addr_700", 32'(bus.mem_addr), 32'd0);
        step(1, 0); @(negedge clk); chk("rgb_700", rgb_now(), 32'h000);
                                    chk("valid_700", 32'(bus.valid), 32'd0);

        // Frame wrap with pix_ce held high: frame_start lasts one clk.
        run_to(799, VT - 1);
        pix_ce = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("vwrap_h", 32'(bus.h_cnt), 32'd0);
        chk("vwrap_v", 32'(bus.v_cnt), 32'd0);
        chk("vwrap_fs", 32'(bus.frame_start), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("vwrap_fs_single", 32'(bus.frame_start), 32'd0);
        pix_ce = 1'b0;

        // Mid-frame reset restarts at (0,0).
        run_to(300, 5);
        rst = 1'b1; pix_ce = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_h", 32'(bus.h_cnt), 32'd0);
        chk("mid_rst_v", 32'(bus.v_cnt), 32'd0);
        chk("mid_rst_valid", 32'(bus.valid), 32'd0);
        chk("mid_rst_rgb", rgb_now(), 32'h000);
        @(posedge clk); #1;
        rst = 1'b0; pix_ce = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk); chk("idle_h", 32'(bus.h_cnt), 32'd0);
        step(1, 3);
        @(negedge clk);
        chk("restart_h", 32'(bus.h_cnt), 32'd1);
        chk("restart_v", 32'(bus.v_cnt), 32'd0);

        // Colour bars (composite when the pattern is not built in).
        run_to(85, 1);
        test_mode = 1'b1;
        step(1, 0);
        test_mode = 1'b0;
        step(1, 0);
        @(negedge clk);
        chk("bar_85", rgb_now(), PAT_EN ? 32'hFF0 : 32'hABC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
